// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, TCTRL bit indices and seven-segment glyphs for the MMIO block
package mmio_pkg;

    localparam logic [5:0] OFF_HEX     = 6'h00;
    localparam logic [5:0] OFF_LEDR    = 6'h04;
    localparam logic [5:0] OFF_LEDG    = 6'h08;
    localparam logic [5:0] OFF_KEY     = 6'h10;
    localparam logic [5:0] OFF_SW      = 6'h14;
    localparam logic [5:0] OFF_KEYEDGE = 6'h18;
    localparam logic [5:0] OFF_TCNT    = 6'h20;
    localparam logic [5:0] OFF_TLIM    = 6'h24;
    localparam logic [5:0] OFF_TCTRL   = 6'h28;

    localparam int TCTRL_READY = 0;
    localparam int TCTRL_OVF   = 1;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/mmio_controller_seven_seg_decoder.sv
// rtl/mmio_controller_seven_seg_decoder.sv - 4-bit nibble to active-low seven-segment hex glyph
module seven_seg_decoder
    import mmio_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_0;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_0;
        endcase
    end

endmodule

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - memory-mapped KEY/SW/HEX/LED registers with debounce, edge capture and interval timer
module mmio_controller
    import mmio_pkg::*;
#(
    parameter int                 DBITS           = 32,
    parameter logic [DBITS-1:0]   IO_BASE         = 32'hF0000000,
    parameter int                 NUM_KEYS        = 4,
    parameter int                 NUM_SW          = 10,
    parameter int                 NUM_LEDR        = 10,
    parameter int                 NUM_LEDG        = 8,
    parameter int                 NUM_HEX         = 6,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 TIMER_PRESCALE  = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DBITS-1:0]      addr,
    input  logic                  wr_en,
    input  logic [DBITS-1:0]      wr_data,
    output logic [DBITS-1:0]      rd_data,
    output logic                  io_hit,
    input  logic [NUM_KEYS-1:0]   key_n,
    input  logic [NUM_SW-1:0]     sw,
    output logic [NUM_LEDR-1:0]   ledr,
    output logic [NUM_LEDG-1:0]   ledg,
    output logic [7*NUM_HEX-1:0]  hex_n
);

    localparam int HEX_BITS = 4 * NUM_HEX;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int PS_W     = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TIMER_PRESCALE - 1);

    logic [5:0]          offset;
    logic                wr_hit;
    logic                we_hex, we_ledr, we_ledg, we_keyedge, we_tcnt, we_tlim, we_tctrl;

    logic [HEX_BITS-1:0] hex_reg;
    logic [NUM_LEDR-1:0] ledr_reg;
    logic [NUM_LEDG-1:0] ledg_reg;

    logic [NUM_KEYS-1:0] key_s1, key_s2, key_sync, key_prev, key_db, key_db_nxt, key_rise, keyedge;
    logic [NUM_SW-1:0]   sw_s1, sw_s2, sw_prev, sw_db, sw_db_nxt;
    logic [DB_W-1:0]     sample_cnt;
    logic                sample_pulse;

    logic [PS_W-1:0]     ps_cnt;
    logic [DBITS-1:0]    tcnt, tlim;
    logic                ready, ovf;
    logic                tick, tcnt_wrap, wrap_evt, ready_clr, ovf_clr, ovf_set;

    assign offset = addr[5:0];
    assign io_hit = (addr[DBITS-1:6] == IO_BASE[DBITS-1:6]);
    assign wr_hit = wr_en && io_hit;

    assign we_hex     = wr_hit && (offset == OFF_HEX);
    assign we_ledr    = wr_hit && (offset == OFF_LEDR);
    assign we_ledg    = wr_hit && (offset == OFF_LEDG);
    assign we_keyedge = wr_hit && (offset == OFF_KEYEDGE);
    assign we_tcnt    = wr_hit && (offset == OFF_TCNT);
    assign we_tlim    = wr_hit && (offset == OFF_TLIM);
    assign we_tctrl   = wr_hit && (offset == OFF_TCTRL);

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
        end else begin
            if (we_hex)  hex_reg  <= wr_data[HEX_BITS-1:0];
            if (we_ledr) ledr_reg <= wr_data[NUM_LEDR-1:0];
            if (we_ledg) ledg_reg <= wr_data[NUM_LEDG-1:0];
        end
    end

    assign ledr = ledr_reg;
    assign ledg = ledg_reg;

    // Synchronisers reset to "released": raw KEY flops hold 1 because the pins are active-low
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    assign key_sync = ~key_s2;

    always_ff @(posedge clk) begin
        if (reset)
            sample_cnt <= '0;
        else if (sample_cnt == DB_LAST)
            sample_cnt <= '0;
        else
            sample_cnt <= sample_cnt + DB_W'(1);
    end

    assign sample_pulse = (sample_cnt == DB_LAST);

    // A bit only follows its input when two consecutive samples agree
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key_db
        assign key_db_nxt[i] = (sample_pulse && (key_sync[i] == key_prev[i])) ? key_sync[i] : key_db[i];
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_db
        assign sw_db_nxt[i] = (sample_pulse && (sw_s2[i] == sw_prev[i])) ? sw_s2[i] : sw_db[i];
    end

    assign key_rise = key_db_nxt & ~key_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev <= '0;
            key_db   <= '0;
            sw_prev  <= '0;
            sw_db    <= '0;
            keyedge  <= '0;
        end else begin
            key_db  <= key_db_nxt;
            sw_db   <= sw_db_nxt;
            if (sample_pulse) begin
                key_prev <= key_sync;
                sw_prev  <= sw_s2;
            end
            keyedge <= key_rise | (keyedge & ~(we_keyedge ? wr_data[NUM_KEYS-1:0] : '0));
        end
    end

    // The TLIM write edge restarts the prescaler, so no tick is taken from the old phase
    assign tick      = (tlim != '0) && (ps_cnt == PS_LAST) && !we_tlim;
    assign tcnt_wrap = (tcnt == tlim - DBITS'(1));
    assign wrap_evt  = tick && !we_tcnt && tcnt_wrap;
    assign ready_clr = we_tctrl && wr_data[TCTRL_READY];
    assign ovf_clr   = we_tctrl && wr_data[TCTRL_OVF];
    assign ovf_set   = wrap_evt && ready && !ready_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt <= '0;
            tcnt   <= '0;
            tlim   <= '0;
            ready  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (we_tlim)
                tlim <= wr_data;

            if (we_tlim)
                ps_cnt <= '0;
            else if (tlim != '0)
                ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);

            if (we_tcnt)
                tcnt <= wr_data;
            else if (tick)
                tcnt <= tcnt_wrap ? '0 : tcnt + DBITS'(1);

            ready <= wrap_evt | (ready & ~ready_clr);
            ovf   <= ovf_set | (ovf & ~ovf_clr);
        end
    end

    always_comb begin
        rd_data = '0;
        if (io_hit) begin
            case (offset)
                OFF_HEX:     rd_data = DBITS'(hex_reg);
                OFF_LEDR:    rd_data = DBITS'(ledr_reg);
                OFF_LEDG:    rd_data = DBITS'(ledg_reg);
                OFF_KEY:     rd_data = DBITS'(key_db);
                OFF_SW:      rd_data = DBITS'(sw_db);
                OFF_KEYEDGE: rd_data = DBITS'(keyedge);
                OFF_TCNT:    rd_data = tcnt;
                OFF_TLIM:    rd_data = tlim;
                OFF_TCTRL: begin
                    rd_data[TCTRL_READY] = ready;
                    rd_data[TCTRL_OVF]   = ovf;
                end
                default:     rd_data = '0;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        seven_seg_decoder u_dec (
            .nibble (hex_reg[4*i +: 4]),
            .seg_n  (hex_n[7*i +: 7])
        );
    end

endmodule
